// File: rtl/lpif_txrx_pkg.sv
// Shared field geometry and helpers for the LPIF <-> logic-link packer.
// Optional even-parity protection of the link word is enabled by LPIF_TXRX_PARITY_EN.
package lpif_txrx_pkg;

   localparam int STATE_W    = 4;
   localparam int PROTID_W   = 2;
   localparam int STATE_LSB  = 0;
   localparam int PROTID_LSB = STATE_LSB + STATE_W;
   localparam int DATA_LSB   = PROTID_LSB + PROTID_W;
   // state + protid + dvalid + crc_valid + valid
   localparam int CTRL_BITS  = STATE_W + PROTID_W + 3;

   function automatic logic [7:0] sat_inc8(input logic [7:0] cnt);
      logic [7:0] res;
      if (cnt == 8'hFF) begin
         res = cnt;
      end else begin
         res = cnt + 8'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/lpif_txrx_sync_fifo.sv
// TX buffer: DEPTH x WIDTH register FIFO whose head word is held in its own register.
// Callers must only push when not full and only pop when not empty.
module lpif_txrx_sync_fifo #(
   parameter  int WIDTH = 141,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int OW    = AW + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic [OW-1:0]    occ_o
);

   localparam logic [OW-1:0] OCC_ONE = OW'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q;
   logic [AW-1:0]    rd_q;
   logic [AW-1:0]    rd_nxt_s;
   logic [OW-1:0]    occ_q;
   logic [WIDTH-1:0] head_q;

   assign rd_nxt_s = rd_q + AW'(1);

   // Storage, pointers, fill level and the registered head word
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_q   <= '0;
         rd_q   <= '0;
         occ_q  <= '0;
         head_q <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_q] <= din_i;
            wr_q        <= wr_q + AW'(1);
         end
         if (pop_i) begin
            rd_q <= rd_nxt_s;
         end
         case ({push_i, pop_i})
            2'b10:   occ_q <= occ_q + OCC_ONE;
            2'b01:   occ_q <= occ_q - OCC_ONE;
            default: occ_q <= occ_q;
         endcase
         // Next head comes from storage unless the pushed word becomes the only entry
         if (pop_i && (occ_q > OCC_ONE)) begin
            head_q <= mem_q[rd_nxt_s];
         end else if (push_i && ((occ_q == '0) || (pop_i && (occ_q == OCC_ONE)))) begin
            head_q <= din_i;
         end
      end
   end

   assign head_o = head_q;
   assign occ_o  = occ_q;

endmodule

// File: rtl/lpif_txrx_packer.sv
// LPIF <-> logic-link packer: buffered TX packing and registered RX unpacking.
// Define LPIF_TXRX_PARITY_EN to append an even-parity MSB to the link word and check it on RX.
module lpif_txrx_packer
   import lpif_txrx_pkg::*;
#(
   parameter  int DATA_WIDTH = 128,
   parameter  int CRC_WIDTH  = 4,
   parameter  int TX_DEPTH   = 4,
   localparam int BASE_W     = DATA_WIDTH + CRC_WIDTH + CTRL_BITS,
`ifdef LPIF_TXRX_PARITY_EN
   localparam int LL_WIDTH   = BASE_W + 1,
`else
   localparam int LL_WIDTH   = BASE_W,
`endif
   localparam int OCC_W      = $clog2(TX_DEPTH) + 1
) (
   input  logic                  clk_wr_i,
   input  logic                  rst_wr_ni,
   input  logic [STATE_W-1:0]    dstrm_state_i,
   input  logic [PROTID_W-1:0]   dstrm_protid_i,
   input  logic [DATA_WIDTH-1:0] dstrm_data_i,
   input  logic                  dstrm_dvalid_i,
   input  logic [CRC_WIDTH-1:0]  dstrm_crc_i,
   input  logic                  dstrm_crc_valid_i,
   input  logic                  dstrm_valid_i,
   output logic                  dstrm_ready_o,
   output logic [LL_WIDTH-1:0]   txfifo_downstream_data_o,
   output logic                  txfifo_downstream_vld_o,
   input  logic                  txfifo_downstream_rdy_i,
   input  logic [LL_WIDTH-1:0]   rxfifo_upstream_data_i,
   input  logic                  rxfifo_upstream_vld_i,
   output logic [STATE_W-1:0]    ustrm_state_o,
   output logic [PROTID_W-1:0]   ustrm_protid_o,
   output logic [DATA_WIDTH-1:0] ustrm_data_o,
   output logic                  ustrm_dvalid_o,
   output logic [CRC_WIDTH-1:0]  ustrm_crc_o,
   output logic                  ustrm_crc_valid_o,
   output logic                  ustrm_valid_o,
   output logic [OCC_W-1:0]      tx_occupancy_o,
   output logic [7:0]            rx_err_cnt_o,
   input  logic                  m_gen2_mode_i
);

   // Declaration order gives the link layout: state at the LSB, valid at the top
   typedef struct packed {
      logic                  valid;
      logic                  crc_valid;
      logic [CRC_WIDTH-1:0]  crc;
      logic                  dvalid;
      logic [DATA_WIDTH-1:0] data;
      logic [PROTID_W-1:0]   protid;
      logic [STATE_W-1:0]    state;
   } lpif_beat_t;

   localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(TX_DEPTH);
   localparam int               HALF_W  = DATA_WIDTH / 2;

   lpif_beat_t          tx_beat_s;
   logic [BASE_W-1:0]   tx_base_s;
   logic [LL_WIDTH-1:0] tx_word_s;
   logic [OCC_W-1:0]    tx_occ_s;
   logic                alive_q;
   logic                push_s;
   logic                pop_s;

   // Pack the downstream beat; gen1 beats carry only the lower half of the data
   always_comb begin
      tx_beat_s.state     = dstrm_state_i;
      tx_beat_s.protid    = dstrm_protid_i;
      tx_beat_s.data      = m_gen2_mode_i ? dstrm_data_i
                                          : {{HALF_W{1'b0}}, dstrm_data_i[HALF_W-1:0]};
      tx_beat_s.dvalid    = dstrm_dvalid_i;
      tx_beat_s.crc       = dstrm_crc_i;
      tx_beat_s.crc_valid = dstrm_crc_valid_i;
      tx_beat_s.valid     = 1'b1;
      tx_base_s           = tx_beat_s;
`ifdef LPIF_TXRX_PARITY_EN
      tx_word_s           = {^tx_base_s, tx_base_s};
`else
      tx_word_s           = tx_base_s;
`endif
   end

   // Holds ready low until the first clock edge after reset release
   always_ff @(posedge clk_wr_i or negedge rst_wr_ni) begin
      if (!rst_wr_ni) begin
         alive_q <= 1'b0;
      end else begin
         alive_q <= 1'b1;
      end
   end

   assign dstrm_ready_o           = alive_q && (tx_occ_s < DEPTH_C);
   assign push_s                  = dstrm_valid_i && dstrm_ready_o;
   assign txfifo_downstream_vld_o = (tx_occ_s != '0);
   assign pop_s                   = txfifo_downstream_vld_o && txfifo_downstream_rdy_i;
   assign tx_occupancy_o          = tx_occ_s;

   lpif_txrx_sync_fifo #(
      .WIDTH (LL_WIDTH),
      .DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .clk_i  (clk_wr_i),
      .rst_ni (rst_wr_ni),
      .push_i (push_s),
      .din_i  (tx_word_s),
      .pop_i  (pop_s),
      .head_o (txfifo_downstream_data_o),
      .occ_o  (tx_occ_s)
   );

   lpif_beat_t          rx_beat_s;
   logic                rx_par_err_s;
   logic                rx_err_s;
   logic [7:0]          err_cnt_d;
   logic [7:0]          err_cnt_q;
   logic [STATE_W-1:0]    st_q;
   logic [PROTID_W-1:0]   pid_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [CRC_WIDTH-1:0]  crc_q;
   logic                  dvalid_q;
   logic                  crc_valid_q;
   logic                  valid_q;

   assign rx_beat_s = rxfifo_upstream_data_i[BASE_W-1:0];
`ifdef LPIF_TXRX_PARITY_EN
   assign rx_par_err_s = rxfifo_upstream_data_i[LL_WIDTH-1] ^ (^rxfifo_upstream_data_i[BASE_W-1:0]);
`else
   assign rx_par_err_s = 1'b0;
`endif
   // Parity and valid/dvalid errors on one word count once
   assign rx_err_s  = rxfifo_upstream_vld_i && (rx_par_err_s || (rx_beat_s.dvalid && !rx_beat_s.valid));
   assign err_cnt_d = rx_err_s ? sat_inc8(err_cnt_q) : err_cnt_q;

   // Upstream field registers; qualifiers drop when no word arrives, fields hold
   always_ff @(posedge clk_wr_i or negedge rst_wr_ni) begin
      if (!rst_wr_ni) begin
         st_q        <= '0;
         pid_q       <= '0;
         data_q      <= '0;
         crc_q       <= '0;
         dvalid_q    <= 1'b0;
         crc_valid_q <= 1'b0;
         valid_q     <= 1'b0;
         err_cnt_q   <= 8'd0;
      end else begin
         err_cnt_q <= err_cnt_d;
         if (rxfifo_upstream_vld_i) begin
            st_q        <= rx_beat_s.state;
            pid_q       <= rx_beat_s.protid;
            data_q      <= rx_beat_s.data;
            crc_q       <= rx_beat_s.crc;
            dvalid_q    <= rx_beat_s.dvalid && !rx_par_err_s;
            crc_valid_q <= rx_beat_s.crc_valid;
            valid_q     <= rx_beat_s.valid && !rx_par_err_s;
         end else begin
            dvalid_q    <= 1'b0;
            crc_valid_q <= 1'b0;
            valid_q     <= 1'b0;
         end
      end
   end

   assign ustrm_state_o     = st_q;
   assign ustrm_protid_o    = pid_q;
   assign ustrm_data_o      = data_q;
   assign ustrm_crc_o       = crc_q;
   assign ustrm_dvalid_o    = dvalid_q;
   assign ustrm_crc_valid_o = crc_valid_q;
   assign ustrm_valid_o     = valid_q;
   assign rx_err_cnt_o      = err_cnt_q;

endmodule

// File: tb/tb_lpif_txrx_packer.sv
// Directed self-checking bench for lpif_txrx_packer (default parameters).
// The parity section runs only when LPIF_TXRX_PARITY_EN is defined.
module tb_lpif_txrx_packer;

`ifdef LPIF_TXRX_PARITY_EN
   localparam int LLW = 142;
`else
   localparam int LLW = 141;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [3:0]     d_state = 4'd0;
   logic [1:0]     d_protid = 2'd0;
   logic [127:0]   d_data = 128'd0;
   logic           d_dvalid = 1'b0;
   logic [3:0]     d_crc = 4'd0;
   logic           d_crc_valid = 1'b0;
   logic           d_valid = 1'b0;
   logic           d_ready;
   logic [LLW-1:0] tx_data;
   logic           tx_vld;
   logic           tx_rdy = 1'b0;
   logic [LLW-1:0] rx_data = '0;
   logic           rx_vld = 1'b0;
   logic [3:0]     u_state;
   logic [1:0]     u_protid;
   logic [127:0]   u_data;
   logic           u_dvalid;
   logic [3:0]     u_crc;
   logic           u_crc_valid;
   logic           u_valid;
   logic [2:0]     occ;
   logic [7:0]     err_cnt;
   logic           gen2 = 1'b1;

   int total = 0;
   int bad   = 0;

   lpif_txrx_packer dut (
      .clk_wr_i                 (clk),
      .rst_wr_ni                (rst_n),
      .dstrm_state_i            (d_state),
      .dstrm_protid_i           (d_protid),
      .dstrm_data_i             (d_data),
      .dstrm_dvalid_i           (d_dvalid),
      .dstrm_crc_i              (d_crc),
      .dstrm_crc_valid_i        (d_crc_valid),
      .dstrm_valid_i            (d_valid),
      .dstrm_ready_o            (d_ready),
      .txfifo_downstream_data_o (tx_data),
      .txfifo_downstream_vld_o  (tx_vld),
      .txfifo_downstream_rdy_i  (tx_rdy),
      .rxfifo_upstream_data_i   (rx_data),
      .rxfifo_upstream_vld_i    (rx_vld),
      .ustrm_state_o            (u_state),
      .ustrm_protid_o           (u_protid),
      .ustrm_data_o             (u_data),
      .ustrm_dvalid_o           (u_dvalid),
      .ustrm_crc_o              (u_crc),
      .ustrm_crc_valid_o        (u_crc_valid),
      .ustrm_valid_o            (u_valid),
      .tx_occupancy_o           (occ),
      .rx_err_cnt_o             (err_cnt),
      .m_gen2_mode_i            (gen2)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Link layout, LSB first: state, protid, data, dvalid, crc, crc_valid, valid [, parity]
   function automatic logic [LLW-1:0] mk_word(input logic [3:0] st, input logic [1:0] pid,
                                              input logic [127:0] d, input logic dv,
                                              input logic [3:0] c, input logic cv, input logic v);
      logic [140:0] base;
      base = {v, cv, c, dv, d, pid, st};
`ifdef LPIF_TXRX_PARITY_EN
      return {^base, base};
`else
      return base;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_beat(input logic [3:0] st, input logic [1:0] pid, input logic [127:0] d,
                             input logic [3:0] c);
      d_state     = st;
      d_protid    = pid;
      d_data      = d;
      d_dvalid    = 1'b1;
      d_crc       = c;
      d_crc_valid = 1'b1;
   endtask

   logic [LLW-1:0] exp_w [4];
   logic [LLW-1:0] w;
   logic [7:0]     err_base;

   initial begin
      // Reset state
      #12;
      check_val("rst_ready",  256'(d_ready), 256'(1'b0));
      check_val("rst_occ",    256'(occ),     256'(3'd0));
      check_val("rst_vld",    256'(tx_vld),  256'(1'b0));
      check_val("rst_txdata", 256'(tx_data), 256'(0));
      check_val("rst_err",    256'(err_cnt), 256'(8'd0));
      check_val("rst_uvalid", 256'(u_valid), 256'(1'b0));
      rst_n = 1'b1;
      #1;
      check_val("ready_pre_edge", 256'(d_ready), 256'(1'b0));
      tick();
      check_val("ready_post_edge", 256'(d_ready), 256'(1'b1));

      // Fill: four pushes with rdy held low
      d_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         drive_beat(4'(k + 1), 2'(k), {4{32'h1000_0000 + 32'(k)}}, 4'(k + 5));
         exp_w[k] = mk_word(4'(k + 1), 2'(k), {4{32'h1000_0000 + 32'(k)}}, 1'b1, 4'(k + 5), 1'b1, 1'b1);
         tick();
         check_val("fill_occ", 256'(occ), 256'(k + 1));
      end
      check_val("full_ready", 256'(d_ready), 256'(1'b0));
      check_val("full_vld",   256'(tx_vld),  256'(1'b1));
      check_val("full_head",  256'(tx_data), 256'(exp_w[0]));
      drive_beat(4'hF, 2'd3, {4{32'hDEAD_BEEF}}, 4'hF);
      tick();
      check_val("full_blocked_occ", 256'(occ), 256'(3'd4));

      // Drain in order
      d_valid = 1'b0;
      tx_rdy  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check_val("drain_head", 256'(tx_data), 256'(exp_w[k]));
         tick();
         check_val("drain_occ", 256'(occ), 256'(3 - k));
      end
      check_val("drain_vld",   256'(tx_vld),  256'(1'b0));
      check_val("drain_ready", 256'(d_ready), 256'(1'b1));

      // Gen1 zeroes upper data half
      tx_rdy = 1'b0;
      gen2   = 1'b0;
      d_valid = 1'b1;
      drive_beat(4'h2, 2'd1, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5, 4'h6);
      tick();
      d_valid = 1'b0;
      w = tx_data;
      check_val("gen1_vld",   256'(tx_vld),    256'(1'b1));
      check_val("gen1_upper", 256'(w[133:70]), 256'(64'h0));
      check_val("gen1_lower", 256'(w[69:6]),   256'(64'hA5A5A5A5_A5A5A5A5));

      // Simultaneous push and pop with one entry
      gen2    = 1'b1;
      d_valid = 1'b1;
      tx_rdy  = 1'b1;
      drive_beat(4'h9, 2'd2, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 4'h3);
      tick();
      d_valid = 1'b0;
      check_val("pushpop_occ",  256'(occ),     256'(3'd1));
      check_val("pushpop_head", 256'(tx_data),
                256'(mk_word(4'h9, 2'd2, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b1, 4'h3, 1'b1, 1'b1)));
      tick();
      check_val("pushpop_drain", 256'(occ), 256'(3'd0));
      tx_rdy = 1'b0;

      // RX load then hold
      rx_data = mk_word(4'h3, 2'd2, 128'hCAFE_0000_0000_0000_0000_0000_0000_BABE, 1'b1, 4'hC, 1'b1, 1'b1);
      rx_vld  = 1'b1;
      tick();
      rx_vld  = 1'b0;
      check_val("rx_valid",  256'(u_valid), 256'(1'b1));
      check_val("rx_state",  256'(u_state), 256'(4'h3));
      check_val("rx_protid", 256'(u_protid), 256'(2'd2));
      check_val("rx_data",   256'(u_data),  256'(128'hCAFE_0000_0000_0000_0000_0000_0000_BABE));
      check_val("rx_crc",    256'(u_crc),   256'(4'hC));
      tick();
      check_val("rx_idle_valid",  256'(u_valid),     256'(1'b0));
      check_val("rx_idle_dvalid", 256'(u_dvalid),    256'(1'b0));
      check_val("rx_idle_crcv",   256'(u_crc_valid), 256'(1'b0));
      check_val("rx_idle_state",  256'(u_state),     256'(4'h3));
      check_val("rx_idle_err",    256'(err_cnt),     256'(8'd0));

`ifdef LPIF_TXRX_PARITY_EN
      // Corrupted bit 10 fails parity
      w = mk_word(4'h5, 2'd1, 128'h1111, 1'b1, 4'h2, 1'b1, 1'b1);
      w[10] = ~w[10];
      rx_data = w;
      rx_vld  = 1'b1;
      tick();
      rx_vld  = 1'b0;
      check_val("par_valid",  256'(u_valid),  256'(1'b0));
      check_val("par_dvalid", 256'(u_dvalid), 256'(1'b0));
      check_val("par_err",    256'(err_cnt),  256'(8'd1));
      // Parity error together with dvalid&!valid counts once
      w = mk_word(4'h5, 2'd1, 128'h1111, 1'b1, 4'h2, 1'b1, 1'b0);
      w[10] = ~w[10];
      rx_data = w;
      rx_vld  = 1'b1;
      tick();
      rx_vld  = 1'b0;
      check_val("par_both_err", 256'(err_cnt), 256'(8'd2));
      err_base = 8'd2;
`else
      err_base = 8'd0;
`endif

      // Saturating error counter
      rx_data = mk_word(4'h7, 2'd0, 128'h55, 1'b1, 4'h1, 1'b0, 1'b0);
      rx_vld  = 1'b1;
      for (int i = 0; i < 300; i++) begin
         tick();
         check_val("sat_uvalid", 256'(u_valid), 256'(1'b0));
         if (i == 0) check_val("sat_first", 256'(err_cnt), 256'(err_base + 8'd1));
         if (i == 252) check_val("sat_near", 256'(err_cnt), 256'(8'd253 + err_base));
      end
      rx_vld = 1'b0;
      check_val("sat_cnt", 256'(err_cnt), 256'(8'd255));

      // Reset in the middle of a burst
      d_valid = 1'b1;
      drive_beat(4'hA, 2'd1, 128'h77, 4'h4);
      tick();
      tick();
      check_val("burst_occ", 256'(occ), 256'(3'd2));
      #2;
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_occ",    256'(occ),     256'(3'd0));
      check_val("mid_rst_vld",    256'(tx_vld),  256'(1'b0));
      check_val("mid_rst_ready",  256'(d_ready), 256'(1'b0));
      check_val("mid_rst_txdata", 256'(tx_data), 256'(0));
      check_val("mid_rst_err",    256'(err_cnt), 256'(8'd0));
      check_val("mid_rst_state",  256'(u_state), 256'(4'd0));
      d_valid = 1'b0;
      #3;
      rst_n = 1'b1;
      tick();
      check_val("post_rst_ready", 256'(d_ready), 256'(1'b1));
      check_val("post_rst_occ",   256'(occ),     256'(3'd0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
